// File: rtl/dac_drive_if.sv
// Sample-in / DAC-out bundle for dac_drive: millivolt sample handshake plus the
// parallel DAC bus (sample clock, code, update strobe).
interface dac_drive_if;
    logic [15:0] volt;
    logic        sign;
    logic        in_valid;
    logic        in_ready;
    logic        da_clk;
    logic [7:0]  da_data;
    logic        da_upd;

    modport master (
        output volt, sign, in_valid,
        input  in_ready, da_clk, da_data, da_upd
    );

    modport slave (
        input  volt, sign, in_valid,
        output in_ready, da_clk, da_data, da_upd
    );
endinterface

// File: rtl/dac_drive.sv
// Signed-mV to 8-bit offset-binary DAC driver with a sys_clk/4 sample clock.
// Optional slew limiting of the DAC code is enabled by defining DAC_SLEW_EN.
module dac_drive #(
    parameter int FULL_MV   = 5000,
    parameter int MID_CODE  = 128,
    parameter int SLEW_STEP = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    dac_drive_if.slave  bus
);

    // Rounded fixed-point gains: code offset = mag * K / 65536.
    localparam int K_POS_I = ((255 - MID_CODE) * 131072 + FULL_MV) / (2 * FULL_MV);
    localparam int K_NEG_I = (MID_CODE * 131072 + FULL_MV) / (2 * FULL_MV);
    localparam logic [27:0]        K_POS = 28'(K_POS_I);
    localparam logic [27:0]        K_NEG = 28'(K_NEG_I);
    localparam logic [15:0]        FULL  = 16'(FULL_MV);
    localparam logic signed [13:0] MID14 = 14'(MID_CODE);
    localparam logic [7:0]         MID8  = 8'(MID_CODE);

    if (SLEW_STEP < 1 || SLEW_STEP > 255) begin : g_bad_step
        $error("dac_drive: SLEW_STEP must be in 1..255");
    end

    typedef struct packed {
        logic [15:0] mag;
        logic        sgn;
    } samp_t;

    logic [1:0]  cnt;
    logic        busy;
    logic        s1_vld;
    samp_t       s1;
    samp_t       samp_in;
    logic        pending;
    logic [7:0]  target;
    logic [7:0]  tgt_nxt;
    logic [7:0]  da_data;
    logic        da_upd;
    logic        accept;
    logic        tick;
    logic [27:0] prod;
    logic [27:0] rnd;
    logic [11:0] off;
    logic signed [13:0] sum;

    assign accept = bus.in_valid && !busy;
    assign tick   = (cnt == 2'd3);

    always_comb begin
        samp_in.mag = (bus.volt > FULL) ? FULL : bus.volt;
        samp_in.sgn = bus.sign && (samp_in.mag != 16'd0);
    end

    always_comb begin
        prod = {12'd0, s1.mag} * (s1.sgn ? K_NEG : K_POS);
        rnd  = prod + 28'd32768;
        off  = 12'(rnd >> 16);
        sum  = s1.sgn ? (MID14 - $signed({2'b00, off})) : (MID14 + $signed({2'b00, off}));
        if (sum < 14'sd0)
            tgt_nxt = 8'd0;
        else if (sum > 14'sd255)
            tgt_nxt = 8'd255;
        else
            tgt_nxt = 8'(sum);
    end

`ifdef DAC_SLEW_EN
    localparam logic [7:0] STEP = 8'(SLEW_STEP);
    logic [7:0] diff;
    logic [7:0] slew_code;
    logic       up;
    logic       at_tgt;

    always_comb begin
        up        = (target >= da_data);
        diff      = up ? (target - da_data) : (da_data - target);
        at_tgt    = (diff <= STEP);
        slew_code = at_tgt ? target : (up ? da_data + STEP : da_data - STEP);
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt     <= 2'd0;
            busy    <= 1'b0;
            s1_vld  <= 1'b0;
            s1      <= '0;
            pending <= 1'b0;
            target  <= MID8;
            da_data <= MID8;
            da_upd  <= 1'b0;
        end else begin
            cnt    <= cnt + 2'd1;
            da_upd <= 1'b0;
            s1_vld <= accept;
            if (accept) begin
                busy <= 1'b1;
                s1   <= samp_in;
            end
            if (s1_vld) begin
                target  <= tgt_nxt;
                pending <= 1'b1;
            end
            // Registered pending: a tick on the same edge as stage 2 waits a full period.
            if (tick && pending) begin
`ifdef DAC_SLEW_EN
                da_data <= slew_code;
                da_upd  <= (diff != 8'd0);
                if (at_tgt) begin
                    pending <= 1'b0;
                    busy    <= 1'b0;
                end
`else
                da_data <= target;
                da_upd  <= 1'b1;
                pending <= 1'b0;
                busy    <= 1'b0;
`endif
            end
        end
    end

    assign bus.in_ready = !busy;
    assign bus.da_clk   = cnt[1];
    assign bus.da_data  = da_data;
    assign bus.da_upd   = da_upd;

endmodule
